// File: rtl/add_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : add_arbiter
//  Purpose  : Shares one external registered adder (1-cycle latency) between
//             NREQ requesters. An IDLE-state arbiter grants one requester,
//             latches its operands and index, drives them to the adder, then
//             captures the sum and holds it until the consumer accepts it.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NREQ  number of requesters (2..8)
//    AW    operand width, sum width is AW+1
//  Ports
//    clk, rst              clock, asynchronous active-high reset
//    req_valid/req_a/req_b per-requester request and packed operands
//    req_ready             one-hot grant strobe (IDLE only)
//    add_a/add_b/add_sum   shared adder operands and registered result
//    rsp_valid/rsp_ready   response handshake
//    rsp_id/rsp_sum        owner index and captured sum
//    busy                  high whenever the FSM is not IDLE
//  Build option
//    ADD_ARBITER_FIXED_PRIO_EN  lowest index always wins (no rotating pointer)
// ============================================================================
module add_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*AW-1:0]        req_a,
    input  logic [NREQ*AW-1:0]        req_b,
    output logic [NREQ-1:0]           req_ready,
    output logic [AW-1:0]             add_a,
    output logic [AW-1:0]             add_b,
    input  logic [AW:0]               add_sum,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [AW:0]               rsp_sum,
    output logic                      busy
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t         r_state;
    logic           w_found;
    logic [IW-1:0]  w_win;
    logic [AW-1:0]  w_sel_a;
    logic [AW-1:0]  w_sel_b;

`ifndef ADD_ARBITER_FIXED_PRIO_EN
    logic [IW-1:0]  r_ptr;
    logic [IW:0]    w_ptr_inc;
    logic [IW-1:0]  w_ptr_nxt;

    // Search from r_ptr upward, wrapping at NREQ; the extra bit keeps the
    // sum from overflowing before the wrap subtraction.
    always_comb begin : p_arb
        logic [IW:0] pos;
        w_found = 1'b0;
        w_win   = '0;
        pos     = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = {1'b0, r_ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(NREQ)) begin
                pos = pos - (IW+1)'(NREQ);
            end
            if (!w_found && req_valid[pos[IW-1:0]]) begin
                w_found = 1'b1;
                w_win   = pos[IW-1:0];
            end
        end
    end

    always_comb begin
        w_ptr_inc = {1'b0, w_win} + (IW+1)'(1);
        w_ptr_nxt = (w_ptr_inc == (IW+1)'(NREQ)) ? '0 : w_ptr_inc[IW-1:0];
    end
`else
    // Fixed priority: first valid requester from index 0 wins.
    always_comb begin : p_arb
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req_valid[k]) begin
                w_found = 1'b1;
                w_win   = IW'(k);
            end
        end
    end
`endif

    // Operand mux for the winning requester.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (IW'(k) == w_win) begin
                w_sel_a = req_a[k*AW +: AW];
                w_sel_b = req_b[k*AW +: AW];
            end
        end
    end

    // Grant is combinational in IDLE; gated by rst so nothing is accepted
    // while reset is held.
    always_comb begin
        req_ready = '0;
        if (!rst && (r_state == IDLE) && w_found) begin
            req_ready[w_win] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
`ifndef ADD_ARBITER_FIXED_PRIO_EN
            r_ptr     <= '0;
`endif
            add_a     <= '0;
            add_b     <= '0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        add_a   <= w_sel_a;
                        add_b   <= w_sel_b;
                        rsp_id  <= w_win;
`ifndef ADD_ARBITER_FIXED_PRIO_EN
                        r_ptr   <= w_ptr_nxt;
`endif
                        busy    <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                // Adder samples add_a/add_b on the edge leaving ISSUE.
                ISSUE: r_state <= WAIT;
                // add_sum now holds the registered result of those operands.
                WAIT: begin
                    rsp_sum   <= add_sum;
                    rsp_valid <= 1'b1;
                    r_state   <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_add_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_add_arbiter
//  Purpose  : Self-checking bench for add_arbiter (NREQ=4, AW=4) with a
//             behavioural registered adder and a reference arbitration model.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_add_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req_valid;
    logic [15:0]   req_a;
    logic [15:0]   req_b;
    logic [3:0]    req_ready;
    logic [3:0]    add_a;
    logic [3:0]    add_b;
    logic [4:0]    add_sum = '0;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [4:0]    rsp_sum;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int last_grant = NREQ - 1;

    add_arbiter #(.NREQ(NREQ), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Shared adder: one register stage, full-width result.
    always @(posedge clk) add_sum <= {1'b0, add_a} + {1'b0, add_b};

    typedef struct {
        logic [3:0]  v;
        logic [15:0] a;
        logic [15:0] b;
        int          hold;
        int          id;
        int          sum;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference arbitration: round robin continues after the last grant.
    function automatic int model_pick(input logic [3:0] v, input int last);
`ifdef ADD_ARBITER_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
        for (int off = 1; off <= NREQ; off++) begin
            int i;
            i = (last + off) % NREQ;
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    // Called at a negedge in IDLE with request inputs already applied.
    task automatic run_op(input int id, input int sum, input int hold);
        int lat;
        logic [3:0] ea, eb;
        ea = req_a[id*4 +: 4];
        eb = req_b[id*4 +: 4];
        rsp_ready = (hold == 0);
        chk("grant_onehot", {60'd0, req_ready}, 64'(1 << id));
        chk("busy_idle", {63'd0, busy}, 64'd0);
        @(posedge clk); @(negedge clk);
        chk("ready_low_issue", {60'd0, req_ready}, 64'd0);
        chk("busy_issue", {63'd0, busy}, 64'd1);
        chk("add_a", {60'd0, add_a}, {60'd0, ea});
        chk("add_b", {60'd0, add_b}, {60'd0, eb});
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'd3);
        chk("rsp_id", {62'd0, rsp_id}, 64'(id));
        chk("rsp_sum", {59'd0, rsp_sum}, 64'(sum));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); @(negedge clk);
            chk("hold_valid", {63'd0, rsp_valid}, 64'd1);
            chk("hold_id", {62'd0, rsp_id}, 64'(id));
            chk("hold_sum", {59'd0, rsp_sum}, 64'(sum));
            chk("hold_ready0", {60'd0, req_ready}, 64'd0);
            chk("hold_busy", {63'd0, busy}, 64'd1);
        end
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("back_idle_valid", {63'd0, rsp_valid}, 64'd0);
        chk("back_idle_busy", {63'd0, busy}, 64'd0);
        last_grant = id;
    endtask

    initial begin
        // Directed vectors; ids assume round robin from a fresh reset.
        tbl[0] = '{4'b1111, 16'h4327, 16'h8F91, 0, 0, 8};
        tbl[1] = '{4'b1111, 16'h4327, 16'h8F91, 0, 1, 11};
        tbl[2] = '{4'b1111, 16'h4327, 16'h8F91, 0, 2, 18};
        tbl[3] = '{4'b1111, 16'h4327, 16'h8F91, 1, 3, 12};
        tbl[4] = '{4'b1111, 16'h4327, 16'h8F91, 0, 0, 8};
        tbl[5] = '{4'b0010, 16'h00F0, 16'h00F0, 0, 1, 30};
        tbl[6] = '{4'b1000, 16'h9000, 16'h6000, 5, 3, 15};
        tbl[7] = '{4'b0101, 16'h0C00, 16'h0A00, 0, 0, 0};
        tbl[8] = '{4'b0101, 16'h0C00, 16'h0A00, 0, 2, 22};
        tbl[9] = '{4'b0001, 16'h0001, 16'h0005, 2, 0, 6};

        rst = 1'b1;
        req_valid = 4'b1111;
        req_a = 16'h1234;
        req_b = 16'h5678;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {60'd0, req_ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_add_a", {60'd0, add_a}, 64'd0);
        chk("rst_add_b", {60'd0, add_b}, 64'd0);
        chk("rst_rsp_id", {62'd0, rsp_id}, 64'd0);
        chk("rst_rsp_sum", {59'd0, rsp_sum}, 64'd0);
        req_valid = 4'b0000;
        rst = 1'b0;
        last_grant = NREQ - 1;
        @(negedge clk);
        chk("idle_no_req", {60'd0, req_ready}, 64'd0);
        chk("idle_no_busy", {63'd0, busy}, 64'd0);

`ifndef ADD_ARBITER_FIXED_PRIO_EN
        for (int i = 0; i < 10; i++) begin
            req_valid = tbl[i].v;
            req_a = tbl[i].a;
            req_b = tbl[i].b;
            #1;
            run_op(tbl[i].id, tbl[i].sum, tbl[i].hold);
        end

        // Reset during WAIT: pointer sits at 1, so requester 1 wins first.
        req_valid = 4'b1111;
        req_a = 16'h4327;
        req_b = 16'h8F91;
        #1;
        chk("pre_abort_grant", {60'd0, req_ready}, 64'd2);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_add_a", {60'd0, add_a}, 64'd0);
        chk("abort_add_b", {60'd0, add_b}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_ready", {60'd0, req_ready}, 64'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("abort_no_rsp", {63'd0, rsp_valid}, 64'd0);
            chk("abort_rsp_sum", {59'd0, rsp_sum}, 64'd0);
            chk("abort_rsp_id", {62'd0, rsp_id}, 64'd0);
        end
        rst = 1'b0;
        last_grant = NREQ - 1;
        #1;
        chk("post_abort_no_rsp", {63'd0, rsp_valid}, 64'd0);
        run_op(0, 8, 0);
`else
        // Fixed priority: req0 keeps winning while it stays valid.
        req_valid = 4'b0101;
        req_a = 16'h0602;
        req_b = 16'h0703;
        #1;
        for (int i = 0; i < 3; i++) run_op(0, 5, 0);
        req_valid = 4'b0100;
        #1;
        run_op(2, 13, 0);
`endif

        // Randomized operations checked against the reference model.
        for (int n = 0; n < 40; n++) begin
            int w, s;
            req_valid = 4'($urandom_range(1, 15));
            req_a = 16'($urandom);
            req_b = 16'($urandom);
            #1;
            w = model_pick(req_valid, last_grant);
            s = int'(req_a[w*4 +: 4]) + int'(req_b[w*4 +: 4]);
            run_op(w, s, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
